aes_block_engine: RTL and testbench
===================================

AES_BLOCK_ENGINE -- requirements
Module: aes_block_engine

Interface
REQ-001 SHALL have parameter KEYLEN_256, default 1, meaning a 256-bit key (8 words) when 1 and a 128-bit key (4 words) when 0.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the width of the BRAM byte address.
REQ-003 SHALL have parameter CNT_W, default 32, meaning the width of the block counter.
REQ-004 aes_clk  in  1  clock; aes_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  pulse; accepted only in IDLE.
REQ-006 cbc_mode  in  1  selects CBC (1) or ECB (0); sampled at start.
REQ-007 num_blocks  in  CNT_W  number of 128-bit blocks; sampled at start.
REQ-008 src_addr  in  ADDR_W  base address of key, then IV (CBC only), then plaintext; sampled at start.
REQ-009 dst_addr  in  ADDR_W  base address for ciphertext; sampled at start.
REQ-010 rd_req  out  1  one-cycle read strobe; rd_addr  out  ADDR_W  read address.
REQ-011 rd_valid  in  1  read data qualifier; rd_data  in  32  read data.
REQ-012 wr_req  out  1  write request, level; wr_addr  out  ADDR_W; wr_data  out  32; wr_ack  in  1  write accepted.
REQ-013 core_init, core_next  out  1  pulses to aes_core; core_ready  in  1; core_keylen  out  1 (=KEYLEN_256); core_encdec  out  1 (tied 1).
REQ-014 core_key  out  256; core_block  out  128; core_result  in  128.
REQ-015 busy  out  1; done  out  1  one-cycle pulse; error  out  1  one-cycle pulse; blocks_done  out  CNT_W; last_result  out  128.

Function
REQ-016 Words SHALL be big-endian: the first word read lands in the most significant 32 bits; for a 128-bit key, core_key[127:0] SHALL be 0.
REQ-017 Addresses SHALL advance by 4 per word, wrapping modulo 2^ADDR_W.
REQ-018 Read protocol: one outstanding read; rd_req high for exactly one cycle; the next rd_req is issued no earlier than the cycle after rd_valid.
REQ-019 Write protocol: wr_req, wr_addr and wr_data held stable until the cycle wr_ack=1; the next word is presented on the following cycle.
REQ-020 States: IDLE, LOAD_KEY, KEY_INIT, WAIT_KEY, LOAD_IV, LOAD_BLK, START_BLK, WAIT_BLK, WRITE_RES, DONE.
REQ-021 IDLE: start=1 with num_blocks=0 -> error pulse, remain IDLE; start=1 with num_blocks!=0 -> latch inputs, set busy, go to LOAD_KEY.
REQ-022 LOAD_KEY: read KEY_WORDS words -> KEY_INIT.
REQ-023 KEY_INIT: wait for core_ready=1, pulse core_init for one cycle -> WAIT_KEY.
REQ-024 WAIT_KEY: on core_ready=1 (no earlier than 1 cycle after core_init) -> LOAD_IV if CBC, else LOAD_BLK.
REQ-025 LOAD_IV: read 4 words into the chaining register -> LOAD_BLK.
REQ-026 LOAD_BLK: read 4 words -> START_BLK.
REQ-027 START_BLK: core_block = plaintext XOR chain in CBC, plaintext in ECB; wait for core_ready=1, pulse core_next for one cycle -> WAIT_BLK.
REQ-028 WAIT_BLK: on core_ready=1, capture core_result into last_result (and into the chain register in CBC) -> WRITE_RES.
REQ-029 WRITE_RES: write 4 words to dst_addr+16*i, then increment blocks_done.
REQ-030 After WRITE_RES: blocks_done==num_blocks -> DONE; else -> LOAD_BLK.
REQ-031 The key expansion SHALL run once per job; no core_init is issued between blocks.
REQ-032 DONE: done pulse for 1 cycle, busy cleared, -> IDLE.
REQ-033 start asserted while busy SHALL be ignored, with no effect on the running job.
REQ-034 Source reads SHALL be contiguous: key, IV, then blocks, with no gaps.
REQ-035 Destination writes SHALL be contiguous from dst_addr.

Reset
REQ-036 On aes_rst_n=0, immediately: state IDLE; rd_req, wr_req, core_init, core_next, busy, done, error = 0; blocks_done, last_result, key, block and chain registers = 0; addresses = 0.
REQ-037 Reset mid-job SHALL abandon the job with no further rd_req or wr_req, and no done pulse.
REQ-038 core reset SHALL be driven from aes_rst_n re-registered on aes_clk.

Verification
REQ-039 Scenario: KEYLEN_256=1, ECB, key 000102..1f, pt 00112233445566778899aabbccddeeff, num_blocks=1 -> writes 8ea2b7ca,516745bf,eafc4990,4b496089; then done.
REQ-040 Scenario: KEYLEN_256=0, ECB, key 000102..0f, same pt -> last_result 69c4e0d86a7b0430d8cdb78070b4c55a; core_key[127:0]=0.
REQ-041 Scenario: CBC, IV=0, 2 identical blocks -> block0 matches ECB; block1 = E(pt XOR ct0) != ct0; exactly one core_init and two core_next.
REQ-042 Scenario: num_blocks=0 -> error pulse, no rd_req; then start again while busy -> ignored, single done.
REQ-043 Scenario: random rd_valid latency 1-8 and wr_ack stalls 0-5 -> results identical; wr_data stable while stalled; never more than 1 read outstanding.
REQ-044 Scenario: reset asserted in WAIT_BLK -> all outputs 0 within the same cycle; a new job runs cleanly afterwards.

Source files
------------

// File: rtl/aes_block_engine.sv
// Sequences one AES job: fetches key, optional IV and plaintext blocks over a
// one-outstanding read port, drives an external aes_core and writes ciphertext back.
//
// state     | meaning
// IDLE      | waiting for start
// LOAD_KEY  | reading key words
// KEY_INIT  | waiting for core ready, then pulsing core_init
// WAIT_KEY  | key expansion running in the core
// LOAD_IV   | reading the CBC initial vector into the chain register
// LOAD_BLK  | reading one plaintext block
// START_BLK | presenting the block, then pulsing core_next
// WAIT_BLK  | block encryption running in the core
// WRITE_RES | writing the four result words
// DONE      | one-cycle done pulse, back to IDLE
module aes_block_engine #(
    parameter int KEYLEN_256 = 1,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic              aes_clk,
    input  logic              aes_rst_n,
    input  logic              start,
    input  logic              cbc_mode,
    input  logic [CNT_W-1:0]  num_blocks,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [31:0]       rd_data,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    input  logic              wr_ack,
    output logic              core_rst_n,
    output logic              core_init,
    output logic              core_next,
    input  logic              core_ready,
    output logic              core_keylen,
    output logic              core_encdec,
    output logic [255:0]      core_key,
    output logic [127:0]      core_block,
    input  logic [127:0]      core_result,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  blocks_done,
    output logic [127:0]      last_result
);

    typedef enum logic [3:0] {
        IDLE, LOAD_KEY, KEY_INIT, WAIT_KEY, LOAD_IV,
        LOAD_BLK, START_BLK, WAIT_BLK, WRITE_RES, DONE
    } state_t;

    localparam logic [2:0] KEY_LAST = (KEYLEN_256 != 0) ? 3'd7 : 3'd3;

    state_t           state;
    logic             cbc_q;
    logic [CNT_W-1:0] num_q;
    logic [2:0]       word_cnt;
    logic             rd_pend;
    logic [127:0]     blk_q;
    logic [127:0]     chain_q;
    logic             rd_phase;
    logic [7:0]       key_lsb;
    logic [6:0]       blk_lsb;
    logic [1:0]       wr_nxt;
    logic [6:0]       wr_lsb;

    assign core_keylen = (KEYLEN_256 != 0);
    assign core_encdec = 1'b1;
    assign rd_phase    = (state == LOAD_KEY) || (state == LOAD_IV) || (state == LOAD_BLK);
    // Big-endian packing: word 0 goes to the top of the register.
    assign key_lsb     = {~word_cnt, 5'b0};
    assign blk_lsb     = {~word_cnt[1:0], 5'b0};
    assign wr_nxt      = word_cnt[1:0] + 2'd1;
    assign wr_lsb      = {~wr_nxt, 5'b0};

    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) core_rst_n <= 1'b0;
        else            core_rst_n <= 1'b1;
    end

    always_ff @(posedge aes_clk or negedge aes_rst_n) begin
        if (!aes_rst_n) begin
            state       <= IDLE;
            cbc_q       <= 1'b0;
            num_q       <= '0;
            word_cnt    <= '0;
            rd_pend     <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_key    <= '0;
            core_block  <= '0;
            blk_q       <= '0;
            chain_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            blocks_done <= '0;
            last_result <= '0;
        end else begin
            rd_req    <= 1'b0;
            core_init <= 1'b0;
            core_next <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;

            if (rd_phase) begin
                if (!rd_pend) begin
                    rd_req  <= 1'b1;
                    rd_pend <= 1'b1;
                end else if (rd_valid) begin
                    rd_pend <= 1'b0;
                    rd_addr <= rd_addr + ADDR_W'(4);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_blocks == '0) begin
                            error <= 1'b1;
                        end else begin
                            busy        <= 1'b1;
                            cbc_q       <= cbc_mode;
                            num_q       <= num_blocks;
                            rd_addr     <= src_addr;
                            wr_addr     <= dst_addr;
                            blocks_done <= '0;
                            word_cnt    <= '0;
                            state       <= LOAD_KEY;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (rd_pend && rd_valid) begin
                        core_key[key_lsb +: 32] <= rd_data;
                        if (word_cnt == KEY_LAST) begin
                            word_cnt <= '0;
                            state    <= KEY_INIT;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end
                KEY_INIT: begin
                    if (core_ready) begin
                        core_init <= 1'b1;
                        state     <= WAIT_KEY;
                    end
                end
                WAIT_KEY: begin
                    // The core only drops ready after it has seen the init pulse.
                    if (!core_init && core_ready) state <= cbc_q ? LOAD_IV : LOAD_BLK;
                end
                LOAD_IV, LOAD_BLK: begin
                    if (rd_pend && rd_valid) begin
                        if (state == LOAD_IV) chain_q[blk_lsb +: 32] <= rd_data;
                        else                  blk_q[blk_lsb +: 32]   <= rd_data;
                        if (word_cnt == 3'd3) begin
                            word_cnt <= '0;
                            state    <= (state == LOAD_IV) ? LOAD_BLK : START_BLK;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end
                START_BLK: begin
                    core_block <= cbc_q ? (blk_q ^ chain_q) : blk_q;
                    if (core_ready) begin
                        core_next <= 1'b1;
                        state     <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (!core_next && core_ready) begin
                        last_result <= core_result;
                        if (cbc_q) chain_q <= core_result;
                        wr_req   <= 1'b1;
                        wr_data  <= core_result[127:96];
                        word_cnt <= '0;
                        state    <= WRITE_RES;
                    end
                end
                WRITE_RES: begin
                    if (wr_ack) begin
                        wr_addr <= wr_addr + ADDR_W'(4);
                        if (word_cnt == 3'd3) begin
                            wr_req      <= 1'b0;
                            word_cnt    <= '0;
                            blocks_done <= blocks_done + CNT_W'(1);
                            state       <= ((blocks_done + CNT_W'(1)) == num_q) ? DONE : LOAD_BLK;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                            wr_data  <= last_result[wr_lsb +: 32];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_engine.sv
// Bench for aes_block_engine: BRAM and aes_core responders, write scoreboard,
// directed jobs on a 256-bit (inst 0) and a 128-bit (inst 1) engine.
module tb_aes_block_engine;

    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic aes_clk = 1'b0;
    logic aes_rst_n;
    logic        cbc_mode;
    logic [31:0] num_blocks, src_addr, dst_addr;

    logic         start[2];
    logic         rd_req[2], rd_valid[2], wr_req[2], wr_ack[2];
    logic [31:0]  rd_addr[2], rd_data[2], wr_addr[2], wr_data[2];
    logic         core_rst_n[2], core_init[2], core_next[2], core_ready[2];
    logic         core_keylen[2], core_encdec[2];
    logic [255:0] core_key[2];
    logic [127:0] core_block[2], core_result[2], last_result[2];
    logic         busy[2], done[2], error[2];
    logic [31:0]  blocks_done[2];

    logic [31:0]  mem[0:1023];
    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           lat_max = 1;
    int           stall_max = 0;

    // responder state
    bit           rd_out[2], wr_pend[2];
    int           rd_cnt[2], wr_cnt[2], core_cnt[2];
    logic [31:0]  rd_a[2], rd_exp[2], wa[2], wd[2];
    logic [255:0] kreg[2];
    logic [127:0] pend_res[2];
    int           n_rd[2], n_init[2], n_next[2], n_done[2], n_err[2];

    always #5 aes_clk = ~aes_clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        aes_block_engine #(.KEYLEN_256(g == 0 ? 1 : 0), .ADDR_W(32), .CNT_W(32)) dut (
            .aes_clk(aes_clk), .aes_rst_n(aes_rst_n), .start(start[g]),
            .cbc_mode(cbc_mode), .num_blocks(num_blocks),
            .src_addr(src_addr), .dst_addr(dst_addr),
            .rd_req(rd_req[g]), .rd_addr(rd_addr[g]), .rd_valid(rd_valid[g]), .rd_data(rd_data[g]),
            .wr_req(wr_req[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]), .wr_ack(wr_ack[g]),
            .core_rst_n(core_rst_n[g]), .core_init(core_init[g]), .core_next(core_next[g]),
            .core_ready(core_ready[g]), .core_keylen(core_keylen[g]), .core_encdec(core_encdec[g]),
            .core_key(core_key[g]), .core_block(core_block[g]), .core_result(core_result[g]),
            .busy(busy[g]), .done(done[g]), .error(error[g]),
            .blocks_done(blocks_done[g]), .last_result(last_result[g])
        );
    end

    // Stand-in cipher: known FIPS-197 vectors, otherwise an arbitrary fixed mix.
    function automatic logic [127:0] core_model(input logic [255:0] k, input logic [127:0] b);
        if (k == K256 && b == PT) return CT256;
        if (k == {K128, 128'h0} && b == PT) return CT128;
        return {b[95:0], b[127:96]} ^ k[255:128] ^ k[127:0] ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put128(input logic [31:0] a, input logic [127:0] v);
        for (int j = 0; j < 4; j++) mem[a[11:2] + 10'(j)] = v[127-32*j -: 32];
    endtask

    task automatic push_blk(input int g, input logic [31:0] base, input logic [127:0] v);
        for (int j = 0; j < 4; j++) begin
            exp_t e;
            e.inst = g;
            e.addr = base + 32'(4 * j);
            e.data = v[127-32*j -: 32];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int g, input logic cbc, input logic [31:0] nb,
                               input logic [31:0] src, input logic [31:0] dst);
        @(negedge aes_clk);
        cbc_mode = cbc; num_blocks = nb; src_addr = src; dst_addr = dst;
        start[g] = 1'b1;
        @(negedge aes_clk);
        start[g] = 1'b0;
    endtask

    task automatic start_job(input int g, input logic cbc, input logic [31:0] nb,
                             input logic [31:0] src, input logic [31:0] dst);
        rd_exp[g] = src;
        pulse_start(g, cbc, nb, src, dst);
    endtask

    task automatic wait_done(input int g);
        bit seen = 0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge aes_clk);
            if (done[g]) seen = 1;
        end
        #2;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout inst %0d: got no done within 5000 cycles", g);
        end
    endtask

    // BRAM read/write and aes_core responders, all acting on the falling edge.
    initial begin
        for (int g = 0; g < 2; g++) begin
            rd_valid[g] = 0; rd_data[g] = 0; wr_ack[g] = 0;
            core_ready[g] = 1; core_result[g] = 0;
        end
        forever begin
            @(negedge aes_clk);
            for (int g = 0; g < 2; g++) begin
                rd_valid[g] = 1'b0;
                wr_ack[g]   = 1'b0;
                if (done[g])  n_done[g]++;
                if (error[g]) n_err[g]++;
                if (!aes_rst_n) begin
                    rd_out[g] = 0; wr_pend[g] = 0; core_cnt[g] = 0; core_ready[g] = 1'b1;
                end else begin
                    if (rd_req[g]) begin
                        n_rd[g]++;
                        checks += 2;
                        if (rd_out[g]) begin
                            errors++;
                            $display("FAIL rd_outstanding inst %0d: got second rd_req at %h", g, rd_addr[g]);
                        end
                        if (rd_addr[g] !== rd_exp[g]) begin
                            errors++;
                            $display("FAIL rd_addr inst %0d: got %h expected %h", g, rd_addr[g], rd_exp[g]);
                        end
                        rd_out[g] = 1; rd_a[g] = rd_addr[g]; rd_exp[g] = rd_addr[g] + 32'd4;
                        rd_cnt[g] = $urandom_range(lat_max, 1);
                    end else if (rd_out[g]) begin
                        rd_cnt[g]--;
                        if (rd_cnt[g] == 0) begin
                            rd_valid[g] = 1'b1; rd_data[g] = mem[rd_a[g][11:2]]; rd_out[g] = 0;
                        end
                    end
                    if (wr_req[g]) begin
                        if (!wr_pend[g]) begin
                            wr_pend[g] = 1; wa[g] = wr_addr[g]; wd[g] = wr_data[g];
                            wr_cnt[g] = $urandom_range(stall_max, 0);
                        end else begin
                            checks++;
                            if (wr_addr[g] !== wa[g] || wr_data[g] !== wd[g]) begin
                                errors++;
                                $display("FAIL wr_stable inst %0d: got %h/%h expected %h/%h",
                                         g, wr_addr[g], wr_data[g], wa[g], wd[g]);
                            end
                        end
                        if (wr_cnt[g] == 0) begin
                            wr_ack[g] = 1'b1; wr_pend[g] = 0;
                        end else begin
                            wr_cnt[g]--;
                        end
                    end
                    if (core_init[g] || core_next[g]) begin
                        checks++;
                        if (!core_ready[g]) begin
                            errors++;
                            $display("FAIL core_busy inst %0d: got init/next while core_ready=0", g);
                        end
                        if (core_init[g]) begin
                            n_init[g]++; kreg[g] = core_key[g]; core_cnt[g] = 4;
                        end else begin
                            n_next[g]++; pend_res[g] = core_model(kreg[g], core_block[g]); core_cnt[g] = 6;
                        end
                    end else if (core_cnt[g] != 0) begin
                        core_ready[g] = 1'b0;
                        core_cnt[g]--;
                        if (core_cnt[g] == 0) begin
                            core_ready[g] = 1'b1; core_result[g] = pend_res[g];
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every accepted write is matched against the queue.
    initial forever begin
        @(negedge aes_clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            if (aes_rst_n && wr_req[g] && wr_ack[g]) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected inst %0d: got %h @ %h expected no write", g, wr_data[g], wr_addr[g]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.inst != g || e.addr !== wr_addr[g] || e.data !== wr_data[g]) begin
                        errors++;
                        $display("FAIL wr_data inst %0d: got %h @ %h expected %h @ %h (inst %0d)",
                                 g, wr_data[g], wr_addr[g], e.data, e.addr, e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] ct1;
        int b_init, b_next, b_done, b_err, b_rd;
        ct1 = core_model(K256, PT ^ CT256);
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        put128(32'h100, K256[255:128]); put128(32'h110, K256[127:0]); put128(32'h120, PT);
        put128(32'h200, K256[255:128]); put128(32'h210, K256[127:0]);
        put128(32'h220, 128'h0); put128(32'h230, PT); put128(32'h240, PT);
        put128(32'h300, K128); put128(32'h310, PT);
        start[0] = 0; start[1] = 0;
        cbc_mode = 0; num_blocks = 0; src_addr = 0; dst_addr = 0;

        // reset state
        aes_rst_n = 1'b1;
        #1 aes_rst_n = 1'b0;
        #2;
        for (int g = 0; g < 2; g++) begin
            check("rst_ctl", {rd_req[g], wr_req[g], core_init[g], core_next[g], busy[g], done[g], error[g], core_rst_n[g]}, 0);
            check("rst_regs", {blocks_done[g], rd_addr[g], wr_addr[g], last_result[g]}, 0);
            check("rst_core", {core_key[g], core_block[g]}, 0);
        end
        repeat (3) @(negedge aes_clk);
        aes_rst_n = 1'b1;
        repeat (3) @(negedge aes_clk);
        check("core_rst_release", {core_rst_n[0], core_rst_n[1], core_encdec[0], core_keylen[0], core_keylen[1]}, 5'b11110);

        // 256-bit ECB, single block
        push_blk(0, 32'h400, CT256);
        start_job(0, 1'b0, 1, 32'h100, 32'h400);
        wait_done(0);
        check("ecb256_result", last_result[0], CT256);
        check("ecb256_blocks", blocks_done[0], 1);
        check("ecb256_busy", busy[0], 0);
        check("ecb256_key", core_key[0], K256);

        // 128-bit ECB
        push_blk(1, 32'h500, CT128);
        start_job(1, 1'b0, 1, 32'h300, 32'h500);
        wait_done(1);
        check("ecb128_result", last_result[1], CT128);
        check("ecb128_key_lo", core_key[1][127:0], 0);
        check("ecb128_key_hi", core_key[1][255:128], K128);

        // CBC, zero IV, two identical blocks
        b_init = n_init[0]; b_next = n_next[0];
        push_blk(0, 32'h600, CT256);
        push_blk(0, 32'h610, ct1);
        start_job(0, 1'b1, 2, 32'h200, 32'h600);
        wait_done(0);
        check("cbc_result", last_result[0], ct1);
        check("cbc_chain_differs", last_result[0] != CT256, 1);
        check("cbc_blocks", blocks_done[0], 2);
        check("cbc_init_count", n_init[0] - b_init, 1);
        check("cbc_next_count", n_next[0] - b_next, 2);

        // num_blocks=0 error, then start while busy ignored
        b_err = n_err[0]; b_rd = n_rd[0]; b_done = n_done[0];
        start_job(0, 1'b0, 0, 32'h100, 32'h400);
        repeat (5) @(negedge aes_clk);
        #2;
        check("zero_err_pulse", n_err[0] - b_err, 1);
        check("zero_no_read", n_rd[0] - b_rd, 0);
        check("zero_not_busy", busy[0], 0);
        push_blk(0, 32'h800, CT256);
        start_job(0, 1'b0, 1, 32'h100, 32'h800);
        repeat (3) @(negedge aes_clk);
        pulse_start(0, 1'b1, 3, 32'h900, 32'ha00);
        repeat (10) @(negedge aes_clk);
        pulse_start(0, 1'b0, 0, 32'h900, 32'ha00);
        wait_done(0);
        repeat (30) @(negedge aes_clk);
        #2;
        check("busy_ignore_done", n_done[0] - b_done, 1);
        check("busy_ignore_err", n_err[0] - b_err, 1);
        check("busy_ignore_blocks", blocks_done[0], 1);
        check("busy_ignore_result", last_result[0], CT256);

        // random read latency and write stalls, destination wrapping past 2^32
        lat_max = 8; stall_max = 5;
        push_blk(0, 32'hffff_fff8, CT256);
        push_blk(0, 32'h0000_0008, ct1);
        start_job(0, 1'b1, 2, 32'h200, 32'hffff_fff8);
        wait_done(0);
        check("rand_cbc_result", last_result[0], ct1);
        push_blk(1, 32'h7f0, CT128);
        start_job(1, 1'b0, 1, 32'h300, 32'h7f0);
        wait_done(1);
        check("rand_ecb128_result", last_result[1], CT128);
        lat_max = 1; stall_max = 0;

        // reset while waiting on the core for a block
        b_next = n_next[0]; b_done = n_done[0];
        start_job(0, 1'b0, 1, 32'h100, 32'h900);
        for (int i = 0; i < 200 && n_next[0] == b_next; i++) begin
            @(negedge aes_clk);
            #1;
        end
        check("abort_reached_wait_blk", n_next[0] - b_next, 1);
        @(negedge aes_clk);
        #2 aes_rst_n = 1'b0;
        #1;
        check("abort_ctl", {rd_req[0], wr_req[0], core_init[0], core_next[0], busy[0], done[0], error[0], core_rst_n[0]}, 0);
        check("abort_regs", {blocks_done[0], rd_addr[0], wr_addr[0], wr_data[0], last_result[0]}, 0);
        check("abort_core", {core_key[0], core_block[0]}, 0);
        repeat (3) @(negedge aes_clk);
        aes_rst_n = 1'b1;
        repeat (20) @(negedge aes_clk);
        #2;
        check("abort_no_done", n_done[0] - b_done, 0);
        push_blk(0, 32'h400, CT256);
        start_job(0, 1'b0, 1, 32'h100, 32'h400);
        wait_done(0);
        check("post_abort_result", last_result[0], CT256);
        check("post_abort_blocks", blocks_done[0], 1);

        repeat (5) @(negedge aes_clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
